// File: rtl/bank_wbuffer_mc.sv
// Parametrised bank write buffer: per-ID payload store with byte-strobe merge, per-entry valid,
// release-on-read, occupancy status and 1/2-cycle read latency. Optional macro: WBUF_WR_BYPASS_EN.
module bank_wbuffer_mc #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 128,
  parameter int RD_LAT = 1,
  parameter int ID_W   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wbuf_wr_req_i,
  input  logic [ID_W-1:0]     wbuf_wr_id_i,
  input  logic [DATA_W-1:0]   wbuf_wdata_i,
  input  logic [DATA_W/8-1:0] wbuf_wstrb_i,
  input  logic                wbuf_rd_req_i,
  input  logic [ID_W-1:0]     wbuf_rd_id_i,
  input  logic                wbuf_rd_release_i,
  output logic                wbuf_rd_data_valid_o,
  output logic [DATA_W-1:0]   wbuf_rd_data_o,
  output logic                wbuf_rd_err_o,
  output logic [ID_W:0]       wbuf_count_o,
  output logic                wbuf_full_o,
  output logic                wbuf_empty_o,
  output logic [DEPTH-1:0]    wbuf_entry_vld_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(DEPTH);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("bank_wbuffer_mc: RD_LAT must be 1 or 2");
  end
  if (ID_W != $clog2(DEPTH) || DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bank_wbuffer_mc: DEPTH must be a power of two in 2..256 and ID_W is derived");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ID_W:0]     cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              rel, wr_fresh, inc;
  logic [DATA_W-1:0] wr_val, rd_val;
  logic              rd_err;

  always_comb begin
    rel      = wbuf_rd_req_i && wbuf_rd_release_i && vld_q[wbuf_rd_id_i];
    // a write landing on an entry released this cycle behaves as a fresh allocation
    wr_fresh = !vld_q[wbuf_wr_id_i] || (rel && (wbuf_rd_id_i == wbuf_wr_id_i));
    inc      = wbuf_wr_req_i && wr_fresh;

    wr_val = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wbuf_wstrb_i[b])
        wr_val[8*b +: 8] = wbuf_wdata_i[8*b +: 8];
      else if (!wr_fresh)
        wr_val[8*b +: 8] = mem[wbuf_wr_id_i][8*b +: 8];
    end

    rd_err = !vld_q[wbuf_rd_id_i];
    rd_val = rd_err ? '0 : mem[wbuf_rd_id_i];
`ifdef WBUF_WR_BYPASS_EN
    if (wbuf_wr_req_i && (wbuf_wr_id_i == wbuf_rd_id_i)) begin
      rd_err = 1'b0;
      rd_val = wr_val;
    end
`endif

    vld_d = vld_q;
    if (rel)           vld_d[wbuf_rd_id_i] = 1'b0;
    if (wbuf_wr_req_i) vld_d[wbuf_wr_id_i] = 1'b1;

    cnt_d = cnt_q + (ID_W+1)'(inc) - (ID_W+1)'(rel);
  end

  always_ff @(posedge clk_i) begin
    if (wbuf_wr_req_i) mem[wbuf_wr_id_i] <= wr_val;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      vld_q   <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  // first read stage: data holds between requests so the output holds between returns
  logic              s1_vld, s1_err;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= wbuf_rd_req_i;
      s1_err <= wbuf_rd_req_i && rd_err;
      if (wbuf_rd_req_i) s1_data <= rd_val;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_vld, s2_err;
    logic [DATA_W-1:0] s2_data;

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        s2_vld  <= 1'b0;
        s2_err  <= 1'b0;
        s2_data <= '0;
      end else begin
        s2_vld <= s1_vld;
        s2_err <= s1_err;
        if (s1_vld) s2_data <= s1_data;
      end
    end

    assign wbuf_rd_data_valid_o = s2_vld;
    assign wbuf_rd_err_o        = s2_err;
    assign wbuf_rd_data_o       = s2_data;
  end else begin : g_lat1
    assign wbuf_rd_data_valid_o = s1_vld;
    assign wbuf_rd_err_o        = s1_err;
    assign wbuf_rd_data_o       = s1_data;
  end

  assign wbuf_count_o     = cnt_q;
  assign wbuf_full_o      = full_q;
  assign wbuf_empty_o     = empty_q;
  assign wbuf_entry_vld_o = vld_q;

endmodule

// File: tb/tb_bank_wbuffer_mc.sv
// Bench for bank_wbuffer_mc: RD_LAT=1 and RD_LAT=2 instances on shared stimulus, checked
// against a per-entry array model; honours WBUF_WR_BYPASS_EN when defined.
module tb_bank_wbuffer_mc;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 128;
  localparam int NB     = DATA_W / 8;
  localparam int ID_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_req = 1'b0;
  logic [ID_W-1:0]   wr_id = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [NB-1:0]     wstrb = '0;
  logic              rd_req = 1'b0;
  logic [ID_W-1:0]   rd_id = '0;
  logic              rd_rel = 1'b0;

  logic              v1, e1, f1, em1, v2, e2, f2, em2;
  logic [DATA_W-1:0] d1, d2;
  logic [ID_W:0]     c1, c2;
  logic [DEPTH-1:0]  ev1, ev2;

  always #5 clk = ~clk;

  bank_wbuffer_mc #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst_n),
    .wbuf_wr_req_i(wr_req), .wbuf_wr_id_i(wr_id), .wbuf_wdata_i(wdata), .wbuf_wstrb_i(wstrb),
    .wbuf_rd_req_i(rd_req), .wbuf_rd_id_i(rd_id), .wbuf_rd_release_i(rd_rel),
    .wbuf_rd_data_valid_o(v1), .wbuf_rd_data_o(d1), .wbuf_rd_err_o(e1),
    .wbuf_count_o(c1), .wbuf_full_o(f1), .wbuf_empty_o(em1), .wbuf_entry_vld_o(ev1)
  );

  bank_wbuffer_mc #(.DEPTH(DEPTH), .DATA_W(DATA_W), .RD_LAT(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst_n),
    .wbuf_wr_req_i(wr_req), .wbuf_wr_id_i(wr_id), .wbuf_wdata_i(wdata), .wbuf_wstrb_i(wstrb),
    .wbuf_rd_req_i(rd_req), .wbuf_rd_id_i(rd_id), .wbuf_rd_release_i(rd_rel),
    .wbuf_rd_data_valid_o(v2), .wbuf_rd_data_o(d2), .wbuf_rd_err_o(e2),
    .wbuf_count_o(c2), .wbuf_full_o(f2), .wbuf_empty_o(em2), .wbuf_entry_vld_o(ev2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model: entry contents, valid flags, and the read return one step behind
  typedef struct packed {
    logic              v;
    logic              e;
    logic [DATA_W-1:0] d;
  } ret_t;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0]  m_vld = '0;
  ret_t              prev = '0;
  logic [DATA_W-1:0] last1 = '0;
  logic [DATA_W-1:0] last2 = '0;

  task automatic step();
    ret_t              cur;
    logic              relv, fresh;
    logic [DATA_W-1:0] nv;
    int                n;
    cur = '0;
    nv  = '0;
    if (rst_n) begin
      relv  = rd_req && rd_rel && m_vld[rd_id];
      fresh = !m_vld[wr_id] || (relv && (rd_id == wr_id));
      for (int b = 0; b < NB; b++)
        nv[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : (fresh ? 8'h00 : m_mem[wr_id][8*b +: 8]);
      cur.v = rd_req;
      cur.e = !m_vld[rd_id];
      cur.d = m_vld[rd_id] ? m_mem[rd_id] : '0;
`ifdef WBUF_WR_BYPASS_EN
      if (wr_req && (wr_id == rd_id)) begin
        cur.e = 1'b0;
        cur.d = nv;
      end
`endif
      if (relv) m_vld[rd_id] = 1'b0;
      if (wr_req) begin
        m_mem[wr_id] = nv;
        m_vld[wr_id] = 1'b1;
      end
    end else begin
      m_vld = '0;
    end

    @(posedge clk);
    #1;

    if (!rst_n) begin
      cur   = '0;
      prev  = '0;
      last1 = '0;
      last2 = '0;
    end
    if (cur.v)  last1 = cur.d;
    if (prev.v) last2 = prev.d;

    check("l1_valid", DATA_W'(v1), DATA_W'(cur.v));
    check("l1_err",   DATA_W'(e1), DATA_W'(cur.v && cur.e));
    check("l1_data",  d1, last1);
    check("l2_valid", DATA_W'(v2), DATA_W'(prev.v));
    check("l2_err",   DATA_W'(e2), DATA_W'(prev.v && prev.e));
    check("l2_data",  d2, last2);
    prev = cur;

    n = $countones(m_vld);
    check("l1_count", DATA_W'(c1),  DATA_W'(n));
    check("l1_full",  DATA_W'(f1),  DATA_W'(n == DEPTH));
    check("l1_empty", DATA_W'(em1), DATA_W'(n == 0));
    check("l1_vld",   DATA_W'(ev1), DATA_W'(m_vld));
    check("l2_count", DATA_W'(c2),  DATA_W'(n));
    check("l2_full",  DATA_W'(f2),  DATA_W'(n == DEPTH));
    check("l2_empty", DATA_W'(em2), DATA_W'(n == 0));
    check("l2_vld",   DATA_W'(ev2), DATA_W'(m_vld));
  endtask

  task automatic cyc(input logic w, input int wid, input logic [DATA_W-1:0] wd, input logic [NB-1:0] ws,
                     input logic r, input int rid, input logic rl);
    wr_req = w;
    wr_id  = ID_W'(wid);
    wdata  = wd;
    wstrb  = ws;
    rd_req = r;
    rd_id  = ID_W'(rid);
    rd_rel = rl;
    step();
  endtask

  task automatic idle();
    cyc(1'b0, 0, '0, '0, 1'b0, 0, 1'b0);
  endtask

  logic [DATA_W-1:0] pat_aa, pat_11, pat_22, pat_beef, pat_1234, exp5;

  initial begin
    pat_aa   = {16{8'hAA}};
    pat_11   = {16{8'h11}};
    pat_22   = {16{8'h22}};
    pat_beef = {8{16'hBEEF}};
    pat_1234 = {8{16'h1234}};

    // reset then idle
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    check("t1_empty", DATA_W'(em1), DATA_W'(1'b1));
    check("t1_count", DATA_W'(c1), '0);

    // simple write then read without release
    cyc(1'b1, 3, pat_aa, '1, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, '0, '0, 1'b1, 3, 1'b0);
    check("t2_data",  d1, pat_aa);
    check("t2_err",   DATA_W'(e1), '0);
    check("t2_count", DATA_W'(c1), DATA_W'(1));
    idle();
    check("t2_l2_data", d2, pat_aa);

    // byte-strobe merge into a live entry
    cyc(1'b1, 5, pat_11, '1, 1'b0, 0, 1'b0);
    cyc(1'b1, 5, pat_22, 16'h000F, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, '0, '0, 1'b1, 5, 1'b0);
    check("t3_data", d1, {{12{8'h11}}, {4{8'h22}}});
    idle();

    // fill every entry, release one, re-read it
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, i, {$urandom, $urandom, $urandom, $urandom}, '1, 1'b0, 0, 1'b0);
    check("t4_full",  DATA_W'(f1), DATA_W'(1'b1));
    check("t4_count", DATA_W'(c1), DATA_W'(DEPTH));
    cyc(1'b0, 0, '0, '0, 1'b1, 0, 1'b1);
    check("t4_count_rel", DATA_W'(c1), DATA_W'(DEPTH - 1));
    check("t4_vld0",      DATA_W'(ev1[0]), '0);
    cyc(1'b0, 0, '0, '0, 1'b1, 0, 1'b0);
    check("t4_err",  DATA_W'(e1), DATA_W'(1'b1));
    check("t4_data", d1, '0);

    // same-cycle write and read+release on the same id
    cyc(1'b1, 7, pat_1234, '1, 1'b0, 0, 1'b0);
`ifdef WBUF_WR_BYPASS_EN
    exp5 = pat_beef;
`else
    exp5 = pat_1234;
`endif
    cyc(1'b1, 7, pat_beef, '1, 1'b1, 7, 1'b1);
    check("t5_data",  d1, exp5);
    check("t5_vld7",  DATA_W'(ev1[7]), DATA_W'(1'b1));
    check("t5_count", DATA_W'(c1), DATA_W'(DEPTH - 1));
    cyc(1'b0, 0, '0, '0, 1'b1, 7, 1'b0);
    check("t5_after", d1, pat_beef);

    // back-to-back reads with reset landing on the second one
    cyc(1'b0, 0, '0, '0, 1'b1, 1, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 0, '0, '0, 1'b1, 2, 1'b0);
    check("t6_l2_valid", DATA_W'(v2), '0);
    check("t6_vld",      DATA_W'(ev2), '0);
    rst_n = 1'b1;
    cyc(1'b0, 0, '0, '0, 1'b1, 3, 1'b0);
    idle();
    idle();

    // randomized traffic with id bias toward collisions and occasional reset
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(1'($urandom_range(0, 2) != 0),
          $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1)),
          {$urandom, $urandom, $urandom, $urandom},
          ($urandom_range(0, 3) == 0) ? '1 : (($urandom_range(0, 5) == 0) ? '0 : NB'($urandom)),
          1'($urandom_range(0, 1)),
          $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1)),
          1'($urandom_range(0, 2) == 0));
    end
    rst_n = 1'b1;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_wbuffer_mc.md
Name: bank_wbuffer_mc

Overview:
Parametrised successor of the bank write buffer. It stores write payload per write-buffer ID, arriving with the xbar request, until the SRAM controller fetches it. Compared with the fixed 32-entry buffer it adds:
- generic depth and data width
- byte-strobe merge into live entries
- per-entry valid tracking with release-on-read
- occupancy and full/empty status
- configurable read latency and error flagging.

Parameters:
DEPTH, 32, number of entries; power of two, 2..256
DATA_W, 128, entry width in bits; multiple of 8
RD_LAT, 1, read return latency in cycles; legal values 1 or 2
ID_W, $clog2(DEPTH), entry index width; derived, not overridden

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
wbuf_wr_req_i  in  1  write strobe; always accepted, no backpressure
wbuf_wr_id_i  in  ID_W  target entry
wbuf_wdata_i  in  DATA_W  write data
wbuf_wstrb_i  in  DATA_W/8  byte enables
wbuf_rd_req_i  in  1  read request; always accepted
wbuf_rd_id_i  in  ID_W  entry to read
wbuf_rd_release_i  in  1  qualifies wbuf_rd_req_i; frees the entry after the read
wbuf_rd_data_valid_o  out  1  read return strobe
wbuf_rd_data_o  out  DATA_W  read return data
wbuf_rd_err_o  out  1  read targeted an invalid entry; qualified by wbuf_rd_data_valid_o
wbuf_count_o  out  ID_W+1  number of valid entries
wbuf_full_o  out  1  count == DEPTH
wbuf_empty_o  out  1  count == 0
wbuf_entry_vld_o  out  DEPTH  per-entry valid bits

Behaviour:
- Reset: rst_i==0 sampled at a rising edge clears the following:
  - all valid bits and count (so wbuf_empty_o=1, wbuf_full_o=0)
  - the read pipeline (wbuf_rd_data_valid_o=0, wbuf_rd_data_o=0, wbuf_rd_err_o=0)
  - Entry data RAM is not reset.
  - Reset mid-operation discards in-flight reads; no return strobe appears afterwards.
- Write to an invalid entry:
  - allocates the entry and sets its valid bit
  - byte b = wdata byte b if wstrb[b], else 0
  - count +1
- Write to a valid entry: merge. Byte b is replaced only where wstrb[b]=1. Valid bit and count are unchanged.
- wstrb all-zero:
  - on an invalid entry: allocates with zero data
  - on a valid entry: no data change
- Read:
  - Entry content and valid bit are sampled in the request cycle.
  - Result appears RD_LAT cycles later with wbuf_rd_data_valid_o=1 for exactly one cycle.
  - Back-to-back requests every cycle are supported; returns stay in order with no gaps.
- Read of an invalid entry: wbuf_rd_data_o=0 and wbuf_rd_err_o=1 with the strobe. Valid bit and count are unchanged; release is ignored.
- Release: rd_req && rd_release on a valid entry clears its valid bit at the end of the request cycle; count -1.
- Same-cycle write and release, same ID:
  - The read returns pre-write content.
  - The entry ends valid and holds the new write treated as a fresh allocation: unstrobed bytes are 0 and count is unchanged.
- Same-cycle allocation and release, different IDs: count unchanged.
- Outputs between returns: wbuf_rd_data_o holds its last value; wbuf_rd_err_o=0 when the strobe is low.
- Count arithmetic: saturation is impossible by construction. Status outputs are registered and reflect state after the edge.
- Illegal RD_LAT: elaboration error.

Optional Feature:
WBUF_WR_BYPASS_EN.
- Defined: a read in the same cycle as a write to the same ID returns the post-write entry value, i.e. the merged value, or the fresh-allocation value if the entry was invalid or released that cycle. wbuf_rd_err_o=0 in this case.
- Undefined: the read returns pre-write content exactly as specified above.

Test Plan:
1. Reset then idle, DEPTH=32 -> count=0, empty=1, full=0, entry_vld=0, rd_data_valid=0.
2. Write id 3, data 0x..AA (all ones strb); read id 3 without release, RD_LAT=1 -> next cycle valid=1, data 0x..AA, err=0, count stays 1.
3. Write id 5 full 0x1111..; write id 5 wdata 0x2222.. with wstrb=0x000F -> read returns low 4 bytes 0x22, remaining bytes 0x11; count=1.
4. Fill all 32 IDs -> full=1, count=32. Read+release id 0 -> count=31, full=0, entry_vld[0]=0. Re-read id 0 -> err=1, data=0.
5. Same cycle: write id 7 (0xBEEF.., strb all ones) plus read+release id 7 holding 0x1234.. -> without macro the return is 0x1234.., with macro 0xBEEF..; both cases end with entry 7 valid, count unchanged.
6. RD_LAT=2, reads every cycle to ids 1,2,3; assert reset on the 2nd cycle -> at most the return already due in the reset cycle is suppressed, no strobes after reset, all valid bits cleared.
